regfile_wb_arbiter: RTL and testbench

Write-back arbiter and scoreboard for the 16-entry ARM-style register file (R0–R14 stored, R15 supplied externally as the PC). Two producers share the register file's single write port: the ALU path (source A) and the load/memory path (source B). The block accepts at most one write per cycle, registers it onto WE3/WA3/WD3, and diverts writes addressed to R15 to a separate PC-write output. It also keeps a per-register pending-write scoreboard that decode uses for hazard stalls.

---
 rtl/regfile_wb_arbiter.sv | 146 ++++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
//
// Write-back arbiter and pending-write scoreboard for the 16-entry register file.
// R0-R14 live in the register file. R15 is the PC and is held outside it.
// Two producers share the single register-file write port:
//   - source A: the ALU path
//   - source B: the load/memory path
// At most one write is accepted per cycle, and it is registered onto WE3/WA3/WD3.
// A write addressed to R15 goes out on pc_we/pc_wd instead.
// The busy vector marks registers that have an outstanding write, so decode can
// stall on hazards.
//
// Ports:
//   clk, reset        clock and asynchronous active-high reset
//   a_valid/a_addr/a_data/a_ready   ALU write request and its accept
//   b_valid/b_addr/b_data/b_ready   load write request and its accept
//   iss_valid, iss_addr             instruction issue with a destination register
//   busy[2**AW-1:0]                 per-register pending-write flags (registered)
//   WE3, WA3, WD3                   register-file write port (registered)
//   pc_we, pc_wd                    PC write (registered)

module regfile_wb_arbiter #(
    parameter int DATA_W = 32,
    parameter int AW     = 4
) (
    input  logic                 clk,
    input  logic                 reset,

    input  logic                 a_valid,
    input  logic [AW-1:0]        a_addr,
    input  logic [DATA_W-1:0]    a_data,
    output logic                 a_ready,

    input  logic                 b_valid,
    input  logic [AW-1:0]        b_addr,
    input  logic [DATA_W-1:0]    b_data,
    output logic                 b_ready,

    input  logic                 iss_valid,
    input  logic [AW-1:0]        iss_addr,
    output logic [(2**AW)-1:0]   busy,

    output logic                 WE3,
    output logic [AW-1:0]        WA3,
    output logic [DATA_W-1:0]    WD3,
    output logic                 pc_we,
    output logic [DATA_W-1:0]    pc_wd
);

    // The highest register address is the PC.
    localparam logic [AW-1:0] PC_ADDR = '1;

    // Round-robin pointer. When it is 1, source B wins the next contention.
    logic prefer_b;

    logic                a_acc;
    logic                b_acc;
    logic                acc;
    logic [AW-1:0]       acc_addr;
    logic [DATA_W-1:0]   acc_data;
    logic [(2**AW)-1:0]  busy_next;

    // Each ready looks only at the other source's valid, never at its own.
    // When both sources are valid, exactly one of them is ready, so at most
    // one transfer can happen in a cycle.
    always_comb begin
        a_ready = !b_valid || !prefer_b;
        b_ready = !a_valid || prefer_b;
    end

    // Pick the accepted source's address and data for the output stage.
    always_comb begin
        a_acc    = a_valid && a_ready;
        b_acc    = b_valid && b_ready;
        acc      = a_acc || b_acc;
        acc_addr = b_acc ? b_addr : a_addr;
        acc_data = b_acc ? b_data : a_data;
    end

    // Scoreboard next state.
    // First, clear the bits for the write that the output stage is committing.
    // Then apply the issue set last, so that a new producer issuing to the same
    // register at the same edge keeps that register busy.
    always_comb begin
        busy_next = busy;
        if (WE3) begin
            busy_next[WA3] = 1'b0;
        end
        if (pc_we) begin
            busy_next[PC_ADDR] = 1'b0;
        end
        if (iss_valid) begin
            busy_next[iss_addr] = 1'b1;
        end
    end

    // Arbitration pointer: it flips toward the source that was not just served.
    // It resets to 1 so that loads win the first contention.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prefer_b <= 1'b1;
        end else if (b_acc) begin
            prefer_b <= 1'b0;
        end else if (a_acc) begin
            prefer_b <= 1'b1;
        end
    end

    // Output stage, loaded every cycle.
    // The write enables are single-cycle pulses.
    // The address and data registers hold their values when nothing targets them.
    // Reset clears this stage, so a write still held here never reaches the
    // register file.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            WE3   <= 1'b0;
            WA3   <= '0;
            WD3   <= '0;
            pc_we <= 1'b0;
            pc_wd <= '0;
        end else begin
            WE3   <= 1'b0;
            pc_we <= 1'b0;
            if (acc) begin
                if (acc_addr == PC_ADDR) begin
                    pc_we <= 1'b1;
                    pc_wd <= acc_data;
                end else begin
                    WE3 <= 1'b1;
                    WA3 <= acc_addr;
                    WD3 <= acc_data;
                end
            end
        end
    end

    // Pending-write scoreboard register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter
//
// Directed self-checking bench for regfile_wb_arbiter.
// Inputs are driven 1 ns after each rising edge.
// Registered outputs are sampled 1 ns after the edge that loads them.

module tb_regfile_wb_arbiter;

    localparam int DATA_W = 32;
    localparam int AW     = 4;

    logic              clk;
    logic              reset;
    logic              a_valid;
    logic [AW-1:0]     a_addr;
    logic [DATA_W-1:0] a_data;
    logic              a_ready;
    logic              b_valid;
    logic [AW-1:0]     b_addr;
    logic [DATA_W-1:0] b_data;
    logic              b_ready;
    logic              iss_valid;
    logic [AW-1:0]     iss_addr;
    logic [15:0]       busy;
    logic              WE3;
    logic [AW-1:0]     WA3;
    logic [DATA_W-1:0] WD3;
    logic              pc_we;
    logic [DATA_W-1:0] pc_wd;

    int checkCount = 0;
    int passCount  = 0;

    regfile_wb_arbiter #(.DATA_W(DATA_W), .AW(AW)) dut (
        .clk       (clk),
        .reset     (reset),
        .a_valid   (a_valid),
        .a_addr    (a_addr),
        .a_data    (a_data),
        .a_ready   (a_ready),
        .b_valid   (b_valid),
        .b_addr    (b_addr),
        .b_data    (b_data),
        .b_ready   (b_ready),
        .iss_valid (iss_valid),
        .iss_addr  (iss_addr),
        .busy      (busy),
        .WE3       (WE3),
        .WA3       (WA3),
        .WD3       (WD3),
        .pc_we     (pc_we),
        .pc_wd     (pc_wd)
    );

    // 10 ns clock period. Rising edges fall at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic av, input logic [AW-1:0] aa, input logic [DATA_W-1:0] ad,
                                 input logic bv, input logic [AW-1:0] ba, input logic [DATA_W-1:0] bd,
                                 input logic iv, input logic [AW-1:0] ia);
        a_valid   = av;
        a_addr    = aa;
        a_data    = ad;
        b_valid   = bv;
        b_addr    = ba;
        b_data    = bd;
        iss_valid = iv;
        iss_addr  = ia;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0);
    endtask

    initial begin
        reset = 1'b1;
        idle();
        tick();
        checkOutput("rst_we3", {31'b0, WE3}, 32'd0);
        checkOutput("rst_wa3", {28'b0, WA3}, 32'd0);
        checkOutput("rst_wd3", WD3, 32'd0);
        checkOutput("rst_pcwe", {31'b0, pc_we}, 32'd0);
        checkOutput("rst_pcwd", pc_wd, 32'd0);
        checkOutput("rst_busy", {16'b0, busy}, 32'd0);

        // Release reset. With no valid inputs, no write goes out.
        reset = 1'b0;
        tick();
        tick();
        checkOutput("idle_we3", {31'b0, WE3}, 32'd0);
        checkOutput("idle_pcwe", {31'b0, pc_we}, 32'd0);

        // Single ALU write to R3.
        applyStimulus(1'b1, 4'd3, 32'h12345678, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0);
        #1;
        checkOutput("a_ready_alone", {31'b0, a_ready}, 32'd1);
        tick();
        idle();
        checkOutput("a_we3", {31'b0, WE3}, 32'd1);
        checkOutput("a_wa3", {28'b0, WA3}, 32'd3);
        checkOutput("a_wd3", WD3, 32'h12345678);
        tick();
        checkOutput("a_we3_drop", {31'b0, WE3}, 32'd0);
        checkOutput("a_wa3_hold", {28'b0, WA3}, 32'd3);

        // Contention for 4 cycles.
        // The pointer is 1 after the A accept, so the grants go B, A, B, A.
        applyStimulus(1'b1, 4'd1, 32'hAAAA0001, 1'b1, 4'd2, 32'hBBBB0002, 1'b0, 4'd0);
        #1;
        checkOutput("cont0_b_ready", {31'b0, b_ready}, 32'd1);
        checkOutput("cont0_a_ready", {31'b0, a_ready}, 32'd0);
        tick();
        checkOutput("cont0_wa3", {28'b0, WA3}, 32'd2);
        checkOutput("cont0_wd3", WD3, 32'hBBBB0002);
        checkOutput("cont1_a_ready", {31'b0, a_ready}, 32'd1);
        tick();
        checkOutput("cont1_wa3", {28'b0, WA3}, 32'd1);
        checkOutput("cont1_wd3", WD3, 32'hAAAA0001);
        tick();
        checkOutput("cont2_wa3", {28'b0, WA3}, 32'd2);
        tick();
        idle();
        checkOutput("cont3_wa3", {28'b0, WA3}, 32'd1);
        checkOutput("cont3_we3", {31'b0, WE3}, 32'd1);

        // Load write to R15 goes to the PC port.
        // WA3 keeps the 1 from the last register write.
        applyStimulus(1'b0, 4'd0, 32'h0, 1'b1, 4'd15, 32'h00000100, 1'b0, 4'd0);
        tick();
        idle();
        checkOutput("pc_we", {31'b0, pc_we}, 32'd1);
        checkOutput("pc_wd", pc_wd, 32'h00000100);
        checkOutput("pc_we3", {31'b0, WE3}, 32'd0);
        checkOutput("pc_wa3_hold", {28'b0, WA3}, 32'd1);
        tick();
        checkOutput("pc_we_drop", {31'b0, pc_we}, 32'd0);
        checkOutput("pc_busy_unset", {16'b0, busy}, 32'd0);

        // Scoreboard: issue to R5 sets its busy bit, with no combinational path.
        applyStimulus(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0, 1'b1, 4'd5);
        #1;
        checkOutput("sb_no_comb", {16'b0, busy}, 32'd0);
        tick();
        idle();
        checkOutput("sb_set5", {16'b0, busy}, 32'h0020);

        // ALU write to R5, accepted at edge N. Busy clears after edge N+1.
        applyStimulus(1'b1, 4'd5, 32'h55555555, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0);
        tick();
        idle();
        checkOutput("sb_n_busy", {16'b0, busy}, 32'h0020);
        checkOutput("sb_n_wa3", {28'b0, WA3}, 32'd5);
        tick();
        checkOutput("sb_clear5", {16'b0, busy}, 32'h0000);

        // Issue and commit to R5 at the same edge: the set wins.
        applyStimulus(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0, 1'b1, 4'd5);
        tick();
        applyStimulus(1'b1, 4'd5, 32'h66666666, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0);
        tick();
        applyStimulus(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0, 1'b1, 4'd5);
        tick();
        idle();
        checkOutput("sb_set_wins", {16'b0, busy}, 32'h0020);

        // R15 busy is cleared when the PC write commits. R5 stays busy.
        applyStimulus(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0, 1'b1, 4'd15);
        tick();
        applyStimulus(1'b0, 4'd0, 32'h0, 1'b1, 4'd15, 32'h00000200, 1'b0, 4'd0);
        checkOutput("sb_set15", {16'b0, busy}, 32'h8020);
        tick();
        idle();
        checkOutput("sb_pc_wd", pc_wd, 32'h00000200);
        tick();
        checkOutput("sb_clear15", {16'b0, busy}, 32'h0020);

        // Pending write to R7 held in the output stage is dropped by a mid-cycle reset.
        applyStimulus(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0, 1'b1, 4'd7);
        tick();
        applyStimulus(1'b1, 4'd7, 32'h77777777, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0);
        tick();
        idle();
        checkOutput("rp_held_wa3", {28'b0, WA3}, 32'd7);
        checkOutput("rp_busy7", {16'b0, busy}, 32'h00A0);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("rp_async_we3", {31'b0, WE3}, 32'd0);
        checkOutput("rp_async_wa3", {28'b0, WA3}, 32'd0);
        checkOutput("rp_async_wd3", WD3, 32'd0);
        checkOutput("rp_async_busy", {16'b0, busy}, 32'd0);
        tick();
        checkOutput("rp_edge_we3", {31'b0, WE3}, 32'd0);
        #3;
        reset = 1'b0;
        tick();
        checkOutput("rp_after_we3", {31'b0, WE3}, 32'd0);
        checkOutput("rp_after_busy", {16'b0, busy}, 32'd0);

        // After reset the pointer is back to 1, so B wins contention again.
        applyStimulus(1'b1, 4'd1, 32'h1, 1'b1, 4'd2, 32'h2, 1'b0, 4'd0);
        #1;
        checkOutput("rp_ptr_b_ready", {31'b0, b_ready}, 32'd1);
        checkOutput("rp_ptr_a_ready", {31'b0, a_ready}, 32'd0);
        tick();
        idle();
        checkOutput("rp_ptr_wa3", {28'b0, WA3}, 32'd2);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
